// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, FSM state encoding
// and the opcode legality check used before an operation is issued.
package alu_arbiter_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_NOR  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_XOR  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    // Codes outside the ALU's decoded set must never reach the ALU.
    function automatic logic alu_op_legal(input logic [3:0] ctrl);
        case (ctrl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SUB, ALU_SLT,
            ALU_SRL, ALU_SRA, ALU_NOR, ALU_SLTU, ALU_XOR: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_any
);

    logic [IDX_W-1:0] cand_s;

    // Scan requesters starting at ptr and keep the first one found.
    always_comb begin
        grant     = {NUM_REQ{1'b0}};
        grant_idx = {IDX_W{1'b0}};
        grant_any = 1'b0;
        cand_s    = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!grant_any && req[cand_s]) begin
                grant_any     = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = cand_s;
            end else begin
                grant_any = grant_any;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters. One operation at
// a time: accept (IDLE) -> drive ALU (EXEC) -> hold response (RESP).
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [4*NUM_REQ-1:0]      req_ctrl,
    input  logic [DATA_W*NUM_REQ-1:0] req_src1,
    input  logic [DATA_W*NUM_REQ-1:0] req_src2,
    input  logic [5*NUM_REQ-1:0]      req_shamt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_zero,
    output logic                      rsp_cout,
    output logic                      rsp_overflow,
    output logic                      rsp_err,
    output logic [3:0]                alu_ctrl,
    output logic [DATA_W-1:0]         alu_src1,
    output logic [DATA_W-1:0]         alu_src2,
    output logic [4:0]                alu_shamt,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_zero,
    input  logic                      alu_cout,
    input  logic                      alu_overflow
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [3:0]             ctrl_q, ctrl_d;
    logic [DATA_W-1:0]      src1_q, src1_d;
    logic [DATA_W-1:0]      src2_q, src2_d;
    logic [4:0]             shamt_q, shamt_d;
    logic                   illegal_q, illegal_d;
    logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_result_q, rsp_result_d;
    logic                   rsp_zero_q, rsp_zero_d;
    logic                   rsp_cout_q, rsp_cout_d;
    logic                   rsp_ovf_q, rsp_ovf_d;
    logic                   rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0]     arb_grant_s;
    logic [IDX_W-1:0]       arb_idx_s;
    logic                   arb_any_s;
    logic [31:0]            sel_base_s;
    logic [3:0]             sel_ctrl_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (arb_grant_s),
        .grant_idx (arb_idx_s),
        .grant_any (arb_any_s)
    );

    // Next-state, operand latch and response capture for the issue FSM.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        ctrl_d       = ctrl_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        shamt_d      = shamt_q;
        illegal_d    = illegal_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_ovf_d    = rsp_ovf_q;
        rsp_err_d    = rsp_err_q;
        req_ready    = {NUM_REQ{1'b0}};
        sel_base_s   = 32'(arb_idx_s);
        sel_ctrl_s   = req_ctrl[sel_base_s*32'd4 +: 4];
        case (state_q)
            ST_IDLE: begin
                if (arb_any_s) begin
                    req_ready   = arb_grant_s;
                    grant_idx_d = arb_idx_s;
                    // Illegal codes are parked as AND so the ALU never sees them.
                    illegal_d   = !alu_op_legal(sel_ctrl_s);
                    ctrl_d      = alu_op_legal(sel_ctrl_s) ? sel_ctrl_s : ALU_AND;
                    src1_d      = req_src1[sel_base_s*DATA_W +: DATA_W];
                    src2_d      = req_src2[sel_base_s*DATA_W +: DATA_W];
                    shamt_d     = req_shamt[sel_base_s*32'd5 +: 5];
                    state_d     = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (illegal_q) begin
                    rsp_result_d = {DATA_W{1'b0}};
                    rsp_zero_d   = 1'b0;
                    rsp_cout_d   = 1'b0;
                    rsp_ovf_d    = 1'b0;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_cout_d   = alu_cout;
                    rsp_ovf_d    = alu_overflow;
                    rsp_err_d    = 1'b0;
                end
                rsp_valid_d              = {NUM_REQ{1'b0}};
                rsp_valid_d[grant_idx_q] = 1'b1;
                state_d                  = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[grant_idx_q]) begin
                    rsp_valid_d = {NUM_REQ{1'b0}};
                    rr_ptr_d    = (grant_idx_q == IDX_W'(NUM_REQ - 1)) ?
                                  {IDX_W{1'b0}} : grant_idx_q + IDX_W'(1);
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                rsp_valid_d = {NUM_REQ{1'b0}};
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= {IDX_W{1'b0}};
            grant_idx_q  <= {IDX_W{1'b0}};
            ctrl_q       <= 4'b0000;
            src1_q       <= {DATA_W{1'b0}};
            src2_q       <= {DATA_W{1'b0}};
            shamt_q      <= 5'd0;
            illegal_q    <= 1'b0;
            rsp_valid_q  <= {NUM_REQ{1'b0}};
            rsp_result_q <= {DATA_W{1'b0}};
            rsp_zero_q   <= 1'b0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            ctrl_q       <= ctrl_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            shamt_q      <= shamt_d;
            illegal_q    <= illegal_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign alu_ctrl     = ctrl_q;
    assign alu_src1     = src1_q;
    assign alu_src2     = src2_q;
    assign alu_shamt    = shamt_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_cout     = rsp_cout_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with two requesters and a behavioural ALU.
module tb_alu_arbiter;

    localparam int N = 2;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [4*N-1:0]   req_ctrl;
    logic [W*N-1:0]   req_src1, req_src2;
    logic [5*N-1:0]   req_shamt;
    logic [W-1:0]     rsp_result, alu_src1, alu_src2, alu_result;
    logic             rsp_zero, rsp_cout, rsp_overflow, rsp_err;
    logic [3:0]       alu_ctrl;
    logic [4:0]       alu_shamt;
    logic             alu_zero, alu_cout, alu_overflow;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
        .req_src1(req_src1), .req_src2(req_src2), .req_shamt(req_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
        .rsp_err(rsp_err), .alu_ctrl(alu_ctrl), .alu_src1(alu_src1),
        .alu_src2(alu_src2), .alu_shamt(alu_shamt), .alu_result(alu_result),
        .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_overflow(alu_overflow)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
    } rsp_t;

    typedef struct {
        int          idx;
        rsp_t        r;
        logic [3:0]  actl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } exp_t;

    // What the requester should get back for an op; illegal codes give err.
    function automatic rsp_t ref_op(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] sh);
        rsp_t o;
        logic [32:0] w;
        o = '0;
        w = 33'd0;
        case (op)
            4'b0000: o.res = a & b;
            4'b0001: o.res = a | b;
            4'b0010: begin
                w = {1'b0, a} + {1'b0, b};
                o.res = w[31:0]; o.c = w[32];
                o.v = (a[31] == b[31]) && (o.res[31] != a[31]);
            end
            4'b0011: o.res = b << sh;
            4'b0110: begin
                w = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.res = w[31:0]; o.c = w[32];
                o.v = (a[31] != b[31]) && (o.res[31] != a[31]);
            end
            4'b0111: o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: o.res = b >> sh;
            4'b1001: o.res = $signed(b) >>> sh;
            4'b1010: o.res = ~(a | b);
            4'b1011: o.res = (a < b) ? 32'd1 : 32'd0;
            4'b1100: o.res = a ^ b;
            default: o.e = 1'b1;
        endcase
        o.z = (o.res == 32'd0) && !o.e;
        return o;
    endfunction

    // Behavioural ALU seen by the DUT.
    rsp_t alu_o;
    always_comb alu_o = ref_op(alu_ctrl, alu_src1, alu_src2, alu_shamt);
    assign alu_result   = alu_o.res;
    assign alu_zero     = alu_o.z;
    assign alu_cout     = alu_o.c;
    assign alu_overflow = alu_o.v;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    exp_t   q[$];
    int     cyc = 0;
    int     acc_cyc = 0;
    logic   idle_m = 1'b1;
    int     ptr_m = 0;
    logic [N-1:0] m_eg;
    int     m_j;
    exp_t   m_e;
    logic [3:0] m_op;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            idle_m = 1'b1;
            ptr_m  = 0;
        end else begin
            m_eg = '0;
            m_j  = -1;
            if (idle_m) begin
                for (int k = 0; k < N; k++) begin
                    if (m_j < 0 && req_valid[(ptr_m + k) % N]) m_j = (ptr_m + k) % N;
                end
                if (m_j >= 0) m_eg[m_j] = 1'b1;
            end
            chk("req_ready", 32'(req_ready), 32'(m_eg));
            if (idle_m) begin
                chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                if (m_j >= 0) begin
                    m_op   = req_ctrl[m_j*4 +: 4];
                    m_e.idx = m_j;
                    m_e.a  = req_src1[m_j*W +: W];
                    m_e.b  = req_src2[m_j*W +: W];
                    m_e.sh = req_shamt[m_j*5 +: 5];
                    m_e.r  = ref_op(m_op, m_e.a, m_e.b, m_e.sh);
                    m_e.actl = m_e.r.e ? 4'd0 : m_op;
                    q.push_back(m_e);
                    idle_m  = 1'b0;
                    acc_cyc = cyc;
                end
            end else if (q.size() > 0) begin
                m_e = q[0];
                if (cyc - acc_cyc == 1) begin
                    chk("rsp_valid_exec", 32'(rsp_valid), 32'd0);
                    chk("alu_ctrl", 32'(alu_ctrl), 32'(m_e.actl));
                    chk("alu_src1", alu_src1, m_e.a);
                    chk("alu_src2", alu_src2, m_e.b);
                    chk("alu_shamt", 32'(alu_shamt), 32'(m_e.sh));
                end else begin
                    chk("rsp_valid", 32'(rsp_valid), 32'(2'b01 << m_e.idx));
                    chk("rsp_result", rsp_result, m_e.r.res);
                    chk("rsp_zero", 32'(rsp_zero), 32'(m_e.r.z));
                    chk("rsp_cout", 32'(rsp_cout), 32'(m_e.r.c));
                    chk("rsp_overflow", 32'(rsp_overflow), 32'(m_e.r.v));
                    chk("rsp_err", 32'(rsp_err), 32'(m_e.r.e));
                    if (rsp_ready[m_e.idx]) begin
                        void'(q.pop_front());
                        idle_m = 1'b1;
                        ptr_m  = (m_e.idx + 1) % N;
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [N-1:0] acc;

    task automatic step();
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        req_valid[r]       = 1'b1;
        req_ctrl[r*4 +: 4] = op;
        req_src1[r*W +: W] = a;
        req_src2[r*W +: W] = b;
        req_shamt[r*5 +: 5] = sh;
    endtask

    task automatic wait_accept(input int r);
        for (int n = 0; n < 20; n++) begin
            step();
            if (acc[r]) break;
        end
        chk("accept_timeout", 32'(acc[r]), 32'd1);
        req_valid[r] = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60; n++) begin
            if (q.size() == 0 && idle_m) break;
            step();
        end
        chk("drain_timeout", 32'(q.size() == 0 && idle_m), 32'd1);
    endtask

    task automatic check_zero();
        @(negedge clk);
        chk("z_req_ready", 32'(req_ready), 32'd0);
        chk("z_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("z_rsp_result", rsp_result, 32'd0);
        chk("z_rsp_flags", 32'({rsp_zero, rsp_cout, rsp_overflow, rsp_err}), 32'd0);
        chk("z_alu_ctrl", 32'(alu_ctrl), 32'd0);
        chk("z_alu_src", alu_src1 | alu_src2, 32'd0);
        chk("z_alu_shamt", 32'(alu_shamt), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero();
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    time t_acc[4];
    int  i_acc[4];
    int  n_acc;

    initial begin
        rst = 1'b1;
        req_valid = '0; req_ctrl = '0; req_src1 = '0; req_src2 = '0; req_shamt = '0;
        rsp_ready = 2'b11;
        do_reset();

        // 1: single ADD 7+5
        issue(0, 4'b0010, 32'd7, 32'd5, 5'd0);
        wait_accept(0);
        wait_idle();

        // 2: both SUB from rr_ptr 0
        do_reset();
        issue(0, 4'b0110, 32'd3, 32'd3, 5'd0);
        issue(1, 4'b0110, 32'd1, 32'd2, 5'd0);
        wait_accept(0);
        wait_accept(1);
        wait_idle();

        // 3: four back-to-back ops with both held valid
        issue(0, 4'b0010, $urandom, $urandom, 5'd0);
        issue(1, 4'b0010, $urandom, $urandom, 5'd0);
        n_acc = 0;
        for (int n = 0; n < 40 && n_acc < 4; n++) begin
            step();
            for (int r = 0; r < N; r++) begin
                if (acc[r]) begin
                    t_acc[n_acc] = $time;
                    i_acc[n_acc] = r;
                    n_acc++;
                    issue(r, 4'b0010, $urandom, $urandom, 5'd0);
                end
            end
        end
        req_valid = '0;
        chk("b2b_count", 32'(n_acc), 32'd4);
        for (int k = 0; k < 4; k++) chk("b2b_order", 32'(i_acc[k]), 32'(k % 2));
        for (int k = 1; k < 4; k++) chk("b2b_gap", 32'(t_acc[k] - t_acc[k-1]), 32'd30);
        wait_idle();

        // 4: illegal ctrl then a legal op
        issue(1, 4'b1101, 32'h1234_5678, 32'h0000_00FF, 5'd3);
        wait_accept(1);
        wait_idle();
        issue(1, 4'b1100, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0);
        wait_accept(1);
        wait_idle();

        // 5: response back-pressure while the other requester waits
        rsp_ready = 2'b00;
        issue(0, 4'b0111, 32'hFFFF_FFFE, 32'd1, 5'd0);
        wait_accept(0);
        issue(1, 4'b0001, 32'h0000_00A0, 32'h0000_000B, 5'd0);
        repeat (6) step();
        rsp_ready = 2'b11;
        wait_accept(1);
        wait_idle();

        // 6: reset in the middle of an SLL
        issue(0, 4'b0011, 32'd0, 32'd1, 5'd4);
        wait_accept(0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_zero();
        repeat (3) step();
        issue(0, 4'b0011, 32'd0, 32'd1, 5'd4);
        wait_accept(0);
        wait_idle();

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step();
            for (int r = 0; r < N; r++) begin
                if (acc[r]) req_valid[r] = 1'b0;
                if (!req_valid[r]) begin
                    if ($urandom_range(0, 2) == 0)
                        issue(r, 4'($urandom_range(0, 15)), rnd_val(), rnd_val(),
                              5'($urandom_range(0, 31)));
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[r] = 1'b0;
                end
                rsp_ready[r] = ($urandom_range(0, 3) != 0);
            end
        end
        req_valid = '0;
        rsp_ready = 2'b11;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
